// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared FSM states, minimum period and configuration clamping.
package clk_div_pkg;
  typedef enum logic [1:0] {IDLE, RUN, STOP} state_e;
  localparam int unsigned MIN_PERIOD = 2;
  function automatic logic [31:0] clamp_p(input logic [31:0] p);
    return (p < MIN_PERIOD) ? MIN_PERIOD : p;
  endfunction
  function automatic logic [31:0] clamp_h(input logic [31:0] p, input logic [31:0] h);
    return (h == 32'd0) ? 32'd1 : (h >= p) ? p - 32'd1 : h;
  endfunction
endpackage

// File: rtl/clk_div_cfg_shadow.sv
// clk_div_cfg_shadow: valid/ready capture of clamped P/H into a pending slot, copied to active on apply.
module clk_div_cfg_shadow
  import clk_div_pkg::*;
#(
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned DEF_PERIOD = 500,
  parameter int unsigned DEF_HIGH   = 250
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [CNT_W-1:0] cfg_high,
  input  logic             apply,
  output logic [CNT_W-1:0] act_period,
  output logic [CNT_W-1:0] act_high
);
  logic             pend_q, pend_d;
  logic [CNT_W-1:0] pend_p_q, pend_p_d, pend_h_q, pend_h_d;
  logic [CNT_W-1:0] act_p_q, act_p_d, act_h_q, act_h_d;
  logic [CNT_W-1:0] p_eff, h_eff;
  logic             hs, upd;
  assign p_eff      = CNT_W'(clamp_p(32'(cfg_period)));
  assign h_eff      = CNT_W'(clamp_h(32'(p_eff), 32'(cfg_high)));
  assign cfg_ready  = !pend_q;
  assign hs         = cfg_valid && cfg_ready;
  assign upd        = apply && pend_q;
  assign act_period = act_p_q;
  assign act_high   = act_h_q;
  // hs and upd are exclusive, so a capture never lands on its own apply cycle
  always_comb begin
    pend_d   = hs ? 1'b1 : upd ? 1'b0 : pend_q;
    pend_p_d = hs ? p_eff : pend_p_q;
    pend_h_d = hs ? h_eff : pend_h_q;
    act_p_d  = upd ? pend_p_q : act_p_q;
    act_h_d  = upd ? pend_h_q : act_h_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_q   <= 1'b0;
      pend_p_q <= '0;
      pend_h_q <= '0;
      act_p_q  <= CNT_W'(DEF_PERIOD);
      act_h_q  <= CNT_W'(DEF_HIGH);
    end else begin
      pend_q   <= pend_d;
      pend_p_q <= pend_p_d;
      pend_h_q <= pend_h_d;
      act_p_q  <= act_p_d;
      act_h_q  <= act_h_d;
    end
  end
endmodule

// File: rtl/clk_div_prog.sv
// clk_div_prog: programmable-period/high-time clock divider with edge strobes and glitch-free reconfiguration.
module clk_div_prog
  import clk_div_pkg::*;
#(
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned DEF_PERIOD = 500,
  parameter int unsigned DEF_HIGH   = 250
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [CNT_W-1:0] cfg_high,
  output logic             div_clk,
  output logic             tick_rise,
  output logic             tick_fall,
  output logic             busy
);
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, per, hi;
  logic             div_q, div_d, rise_q, rise_d, fall_q, fall_d;
  logic             bnd, last, apply;
  clk_div_cfg_shadow #(.CNT_W(CNT_W), .DEF_PERIOD(DEF_PERIOD), .DEF_HIGH(DEF_HIGH)) u_shadow (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_period(cfg_period),
    .cfg_high  (cfg_high),
    .apply     (apply),
    .act_period(per),
    .act_high  (hi)
  );
  assign bnd       = cnt_q == per - 1'b1;
  assign last      = cnt_q + 1'b1 == hi;
  assign apply     = state_q == IDLE || bnd;
  assign div_clk   = div_q;
  assign tick_rise = rise_q;
  assign tick_fall = fall_q;
  assign busy      = state_q != IDLE;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (state_q == IDLE) begin
      cnt_d   = '0;
      div_d   = en;
      rise_d  = en;
      state_d = en ? RUN : IDLE;
    end else if (bnd) begin
      cnt_d   = '0;
      state_d = (en && state_q == RUN) ? RUN : IDLE;
      div_d   = state_d == RUN;
      rise_d  = div_d;
    end else begin
      cnt_d   = cnt_q + 1'b1;
      div_d   = last ? 1'b0 : div_q;
      fall_d  = last;
      state_d = en ? RUN : STOP;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      div_q   <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end
endmodule

// File: tb/tb_clk_div_prog.sv
// tb_clk_div_prog: edge events queued from directed stimulus, matched by a tick monitor.
module tb_clk_div_prog;
  logic        clk = 1'b0, rst_n, en, cfg_valid, cfg_ready, div_clk, tick_rise, tick_fall, busy;
  logic [15:0] cfg_period, cfg_high;
  int          cyc = 0, total = 0, bad = 0, b;
  typedef struct {bit rise; int cyc;} ev_t;
  ev_t sb[$];
  ev_t e;
  clk_div_prog #(.CNT_W(16), .DEF_PERIOD(500), .DEF_HIGH(250)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_period(cfg_period), .cfg_high(cfg_high), .div_clk(div_clk),
    .tick_rise(tick_rise), .tick_fall(tick_fall), .busy(busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (tick_rise || tick_fall) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_tick: got rise=%0d fall=%0d at cycle %0d, expected no tick", tick_rise, tick_fall, cyc);
      end else begin
        e = sb.pop_front();
        if (e.rise != tick_rise || tick_rise == tick_fall || e.cyc != cyc || div_clk != tick_rise) begin
          bad++;
          $display("FAIL tick: got rise=%0d fall=%0d div=%0d at cycle %0d, expected rise=%0d at cycle %0d",
                   tick_rise, tick_fall, div_clk, cyc, e.rise, e.cyc);
        end
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end
  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", nm, act, exp, cyc);
    end
  endtask
  task automatic wait_cyc(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic push(input bit r, input int c);
    sb.push_back('{rise: r, cyc: c});
  endtask
  task automatic per(input int base, input int p, input int h, input int n);
    for (int i = 0; i < n; i++) begin
      push(1'b1, base + i * p);
      push(1'b0, base + i * p + h);
    end
  endtask
  task automatic cfg(input logic [15:0] p, input logic [15:0] h);
    cfg_valid  = 1'b1;
    cfg_period = p;
    cfg_high   = h;
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
  endtask
  initial begin
    rst_n = 1'b0; en = 1'b0; cfg_valid = 1'b0; cfg_period = '0; cfg_high = '0;
    wait_cyc(3);
    chk("rst_div", int'(div_clk), 0);
    chk("rst_rise", int'(tick_rise), 0);
    chk("rst_fall", int'(tick_fall), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ready", int'(cfg_ready), 1);
    rst_n = 1'b1;
    wait_cyc(5);
    en = 1'b1;
    b = cyc + 1;
    per(b, 500, 250, 1);
    wait_cyc(b + 100);
    cfg(10, 3);
    chk("ready_after_hs", int'(cfg_ready), 0);
    wait_cyc(b + 499);
    chk("ready_at_boundary", int'(cfg_ready), 0);
    wait_cyc(b + 500);
    chk("ready_after_apply", int'(cfg_ready), 1);
    b += 500;
    per(b, 10, 3, 3);
    wait_cyc(b + 25);
    cfg(1, 0);
    b += 30;
    per(b, 2, 1, 4);
    wait_cyc(b + 6);
    cfg(8, 9);
    b += 8;
    per(b, 8, 7, 2);
    wait_cyc(b + 10);
    cfg(10, 5);
    b += 16;
    per(b, 10, 5, 1);
    wait_cyc(b + 2);
    en = 1'b0;
    wait_cyc(b + 5);
    chk("busy_in_stop", int'(busy), 1);
    wait_cyc(b + 10);
    chk("stop_div", int'(div_clk), 0);
    chk("stop_busy", int'(busy), 0);
    wait_cyc(b + 12);
    en = 1'b1;
    b = cyc + 1;
    per(b, 10, 5, 2);
    wait_cyc(b + 3);
    en = 1'b0;
    wait_cyc(b + 6);
    chk("busy_reenable", int'(busy), 1);
    en = 1'b1;
    b += 10;
    wait_cyc(b + 9);
    cfg(6, 4);
    per(b + 10, 10, 5, 1);
    per(b + 20, 6, 4, 1);
    push(1'b1, b + 26);
    b += 26;
    wait_cyc(b + 1);
    cfg(20, 10);
    chk("ready_pending", int'(cfg_ready), 0);
    en = 1'b0;
    rst_n = 1'b0;
    wait_cyc(b + 3);
    chk("midrst_div", int'(div_clk), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_ready", int'(cfg_ready), 1);
    rst_n = 1'b1;
    wait_cyc(b + 6);
    en = 1'b1;
    b = cyc + 1;
    per(b, 500, 250, 1);
    push(1'b1, b + 500);
    wait_cyc(b + 505);
    chk("events_left", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
